// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared sizes, screen limits and FSM encoding for the VGA
//               frame-buffer arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int FB_W_DEF        = 160;
    localparam int FB_H_DEF        = 120;
    localparam int SCALE_SHIFT_DEF = 2;
    localparam int FB_AW           = 15;
    localparam int COLOR_W         = 12;
    localparam int COORD_W         = 11;
    localparam int SCREEN_W        = 640;
    localparam int SCREEN_H        = 480;

    // Never a legal fetch address, so comparing against it always forces a fetch.
    localparam logic [FB_AW-1:0] ADDR_SENTINEL = 15'h7FFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2,
        ST_WR   = 2'd3
    } fsm_state_e;

endpackage
`default_nettype wire

// File: rtl/fb_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : fb_addr_gen
// Description : Maps a screen coordinate to a down-scaled frame-buffer address
//               and flags whether the coordinate is in the visible area.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_addr_gen
    import vga_pkg::*;
#(
    parameter int FB_W        = FB_W_DEF,
    parameter int SCALE_SHIFT = SCALE_SHIFT_DEF
) (
    input  logic [COORD_W-1:0] current_x,
    input  logic [COORD_W-1:0] current_y,
    input  logic               hblank,
    input  logic               vblank,
    output logic [FB_AW-1:0]   fetch_addr,
    output logic               visible
);

    logic [COORD_W-1:0] w_col;
    logic [COORD_W-1:0] w_row;

    assign w_col = current_x >> SCALE_SHIFT;
    assign w_row = current_y >> SCALE_SHIFT;

    assign fetch_addr = FB_AW'(w_row) * FB_AW'(FB_W) + FB_AW'(w_col);

    assign visible = !hblank && !vblank
                  && (current_x < COORD_W'(SCREEN_W))
                  && (current_y < COORD_W'(SCREEN_H));

endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_arbiter
// Description : Shares one single-port frame buffer between VGA pixel fetches
//               (priority) and a writer port; drives RGB444 from a colour reg.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int FB_W          = FB_W_DEF,
    parameter int FB_H          = FB_H_DEF,
    parameter int SCALE_SHIFT   = SCALE_SHIFT_DEF,
    parameter int WR_BLANK_ONLY = 0
) (
    input  logic               CLK_100MHz,
    input  logic               Reset,
    input  logic [COORD_W-1:0] CurrentX,
    input  logic [COORD_W-1:0] CurrentY,
    input  logic               HBlank,
    input  logic               VBlank,
    input  logic               WrValid,
    input  logic [FB_AW-1:0]   WrAddr,
    input  logic [COLOR_W-1:0] WrData,
    output logic               WrReady,
    output logic               WrDropped,
    output logic [FB_AW-1:0]   MemAddr,
    output logic               MemWE,
    output logic [COLOR_W-1:0] MemWData,
    input  logic [COLOR_W-1:0] MemRData,
    output logic [3:0]         RED,
    output logic [3:0]         GREEN,
    output logic [3:0]         BLUE
);

    localparam logic [FB_AW:0] C_FB_SIZE = (FB_AW+1)'(FB_W * FB_H);

    fsm_state_e         r_state,     w_state_n;
    logic [FB_AW-1:0]   r_last_addr, w_last_addr_n;
    logic [COLOR_W-1:0] r_colour,    w_colour_n;
    logic [FB_AW-1:0]   r_mem_addr,  w_mem_addr_n;
    logic               r_mem_we,    w_mem_we_n;
    logic [COLOR_W-1:0] r_mem_wdata, w_mem_wdata_n;
    logic               r_wr_ready,  w_wr_ready_n;
    logic               r_wr_drop,   w_wr_drop_n;

    logic [FB_AW-1:0]   w_fetch_addr;
    logic               w_visible;
    logic               w_disp_req;
    logic               w_wr_grant;
    logic               w_wr_in_range;

    fb_addr_gen #(
        .FB_W        (FB_W),
        .SCALE_SHIFT (SCALE_SHIFT)
    ) u_addr_gen (
        .current_x  (CurrentX),
        .current_y  (CurrentY),
        .hblank     (HBlank),
        .vblank     (VBlank),
        .fetch_addr (w_fetch_addr),
        .visible    (w_visible)
    );

    assign w_disp_req    = w_visible && (w_fetch_addr != r_last_addr);
    assign w_wr_grant    = WrValid && ((WR_BLANK_ONLY == 0) || VBlank);
    assign w_wr_in_range = {1'b0, WrAddr} < C_FB_SIZE;

    always_comb begin
        w_state_n     = r_state;
        // Any blanked cycle invalidates the last fetch so the next line re-fetches.
        w_last_addr_n = w_visible ? r_last_addr : ADDR_SENTINEL;
        w_colour_n    = r_colour;
        w_mem_addr_n  = r_mem_addr;
        w_mem_we_n    = 1'b0;
        w_mem_wdata_n = r_mem_wdata;
        w_wr_ready_n  = 1'b0;
        w_wr_drop_n   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_disp_req) begin
                    w_state_n     = ST_RD;
                    w_last_addr_n = w_fetch_addr;
                    w_mem_addr_n  = w_fetch_addr;
                end else if (w_wr_grant) begin
                    w_state_n     = ST_WR;
                    w_mem_addr_n  = WrAddr;
                    w_mem_wdata_n = WrData;
                    w_mem_we_n    = w_wr_in_range;
                    w_wr_ready_n  = 1'b1;
                    w_wr_drop_n   = !w_wr_in_range;
                end
            end
            ST_RD: begin
                w_state_n = ST_CAP;
            end
            ST_CAP: begin
                w_colour_n = MemRData;
                w_state_n  = ST_IDLE;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_100MHz or posedge Reset) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_last_addr <= ADDR_SENTINEL;
            r_colour    <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_wr_ready  <= 1'b0;
            r_wr_drop   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_last_addr <= w_last_addr_n;
            r_colour    <= w_colour_n;
            r_mem_addr  <= w_mem_addr_n;
            r_mem_we    <= w_mem_we_n;
            r_mem_wdata <= w_mem_wdata_n;
            r_wr_ready  <= w_wr_ready_n;
            r_wr_drop   <= w_wr_drop_n;
        end
    end

    assign MemAddr   = r_mem_addr;
    assign MemWE     = r_mem_we;
    assign MemWData  = r_mem_wdata;
    assign WrReady   = r_wr_ready;
    assign WrDropped = r_wr_drop;

    assign RED   = w_visible ? r_colour[11:8] : 4'h0;
    assign GREEN = w_visible ? r_colour[7:4]  : 4'h0;
    assign BLUE  = w_visible ? r_colour[3:0]  : 4'h0;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_fb_arbiter
// Description : Self-checking bench for vga_fb_arbiter with a frame-buffer
//               model and a golden picture of the expected buffer contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fb_arbiter;

    localparam int FB_SIZE = 19200;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] cur_x, cur_y;
    logic        hblank, vblank, wr_valid;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;

    logic        wr_ready, wr_dropped, mem_we;
    logic [14:0] mem_addr;
    logic [11:0] mem_wdata, mem_rdata;
    logic [3:0]  red, green, blue;

    logic        wr_ready_b, wr_dropped_b, mem_we_b;
    logic [14:0] mem_addr_b;
    logic [11:0] mem_wdata_b, mem_rdata_b;
    logic [3:0]  red_b, green_b, blue_b;

    logic [11:0] mem    [0:FB_SIZE-1];
    logic [11:0] golden [0:FB_SIZE-1];
    logic        mem_clr;
    logic [31:0] seed;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;
    assign mem_rdata_b = 12'h000;

    vga_fb_arbiter dut (
        .CLK_100MHz (clk),     .Reset     (rst),
        .CurrentX   (cur_x),   .CurrentY  (cur_y),
        .HBlank     (hblank),  .VBlank    (vblank),
        .WrValid    (wr_valid), .WrAddr   (wr_addr),  .WrData (wr_data),
        .WrReady    (wr_ready), .WrDropped (wr_dropped),
        .MemAddr    (mem_addr), .MemWE    (mem_we),   .MemWData (mem_wdata),
        .MemRData   (mem_rdata),
        .RED        (red),     .GREEN     (green),    .BLUE   (blue)
    );

    vga_fb_arbiter #(.WR_BLANK_ONLY(1)) dut_b (
        .CLK_100MHz (clk),     .Reset     (rst),
        .CurrentX   (cur_x),   .CurrentY  (cur_y),
        .HBlank     (hblank),  .VBlank    (vblank),
        .WrValid    (wr_valid), .WrAddr   (wr_addr),  .WrData (wr_data),
        .WrReady    (wr_ready_b), .WrDropped (wr_dropped_b),
        .MemAddr    (mem_addr_b), .MemWE    (mem_we_b), .MemWData (mem_wdata_b),
        .MemRData   (mem_rdata_b),
        .RED        (red_b),   .GREEN     (green_b),  .BLUE   (blue_b)
    );

    function automatic logic [11:0] init_pix(input int a, input logic [31:0] s);
        logic [31:0] h;
        if (a == 0) return 12'hF00;
        h = (32'(a) * 32'h9E3779B1) ^ s;
        h = h ^ (h >> 13);
        return h[19:8];
    endfunction

    function automatic int pix_addr(input int x, input int y);
        return (y / 4) * 160 + x / 4;
    endfunction

    // Synchronous-read frame buffer: address sampled at the edge, data the cycle after.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < FB_SIZE; i++) mem[i] <= init_pix(i, seed);
        end else if (mem_we && int'(mem_addr) < FB_SIZE) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= (int'(mem_addr) < FB_SIZE) ? mem[mem_addr] : 12'h000;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int x, input int y);
        cur_x  = 11'(x);
        cur_y  = 11'(y);
        hblank = 1'b0;
        vblank = 1'b0;
    endtask

    task automatic do_write(input logic [14:0] a, input logic [11:0] d, input int bound,
                            output int lat, output logic drop, output logic we,
                            output logic [14:0] ma, output logic [11:0] md);
        lat = -1; drop = 1'bx; we = 1'bx; ma = 'x; md = 'x;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if (wr_ready) begin
                lat = i; drop = wr_dropped; we = mem_we; ma = mem_addr; md = mem_wdata;
                break;
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_clr = 1'b1; hblank = 1'b1; vblank = 1'b1;
        cur_x = '0; cur_y = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        seed = $urandom;
        for (int i = 0; i < FB_SIZE; i++) golden[i] = init_pix(i, seed);
        tick(); tick(); mem_clr = 1'b0; tick();
        hblank = 1'b0; vblank = 1'b0; #1;
        n_checks++; if (mem_addr !== 15'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %0h expected 0", mem_addr); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        n_checks++; if (mem_wdata !== 12'd0) begin n_fail++; $display("FAIL reset_mem_wdata: got %0h expected 0", mem_wdata); end
        n_checks++; if ({wr_ready, wr_dropped} !== 2'b00) begin n_fail++; $display("FAIL reset_wr_flags: got %b expected 00", {wr_ready, wr_dropped}); end
        n_checks++; if ({red, green, blue} !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %0h expected 0", {red, green, blue}); end
        n_checks++; if ({wr_ready_b, wr_dropped_b, mem_we_b, mem_addr_b, mem_wdata_b, red_b, green_b, blue_b} !== '0) begin
            n_fail++; $display("FAIL reset_dut_b: got nonzero outputs expected all 0"); end
        hblank = 1'b1; vblank = 1'b1;
        tick(); rst = 1'b0; tick();
    endtask

    task automatic test_first_pixel();
        set_pix(0, 0);
        tick();
        n_checks++; if ({mem_addr, mem_we} !== {15'd0, 1'b0}) begin n_fail++; $display("FAIL first_rd: got addr %0h we %b expected addr 0 we 0", mem_addr, mem_we); end
        tick();
        n_checks++; if ({red, green, blue} !== 12'h000) begin n_fail++; $display("FAIL first_early: got %0h expected 0", {red, green, blue}); end
        tick();
        n_checks++; if ({red, green, blue} !== golden[0]) begin n_fail++; $display("FAIL first_pixel: got %0h expected %0h", {red, green, blue}, golden[0]); end
    endtask

    task automatic test_write_hblank();
        int lat; logic drop, we; logic [14:0] ma; logic [11:0] md;
        hblank = 1'b1;
        do_write(15'd161, 12'h0A5, 5, lat, drop, we, ma, md);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL wr_latency: got %0d expected 1", lat); end
        n_checks++; if ({we, drop, ma, md} !== {1'b1, 1'b0, 15'd161, 12'h0A5}) begin
            n_fail++; $display("FAIL wr_fields: got we %b drop %b addr %0d data %0h expected 1 0 161 0a5", we, drop, ma, md); end
        golden[161] = 12'h0A5;
        tick();
        n_checks++; if ({wr_ready, mem_we} !== 2'b00) begin n_fail++; $display("FAIL wr_pulse_len: got %b expected 00", {wr_ready, mem_we}); end
        set_pix(4, 4);
        tick(); tick(); tick();
        n_checks++; if ({red, green, blue} !== golden[161]) begin n_fail++; $display("FAIL wr_display: got %0h expected %0h", {red, green, blue}, golden[161]); end
    endtask

    task automatic test_collision();
        logic [11:0] d;
        d = 12'($urandom);
        set_pix(8, 0);
        wr_valid = 1'b1; wr_addr = 15'd5; wr_data = d;
        tick();
        n_checks++; if ({mem_addr, wr_ready, mem_we} !== {15'd2, 2'b00}) begin
            n_fail++; $display("FAIL coll_rd_first: got addr %0d rdy %b we %b expected 2 0 0", mem_addr, wr_ready, mem_we); end
        tick();
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL coll_cap: got %b expected 0", wr_ready); end
        tick();
        n_checks++; if ({red, green, blue} !== golden[2]) begin n_fail++; $display("FAIL coll_pixel: got %0h expected %0h", {red, green, blue}, golden[2]); end
        tick();
        n_checks++; if ({wr_ready, mem_we, mem_addr} !== {2'b11, 15'd5}) begin
            n_fail++; $display("FAIL coll_wr: got rdy %b we %b addr %0d expected 1 1 5", wr_ready, mem_we, mem_addr); end
        wr_valid = 1'b0;
        golden[5] = d;
        set_pix(12, 0);
        tick(); tick(); tick(); tick();
        n_checks++; if ({red, green, blue} !== golden[3]) begin n_fail++; $display("FAIL coll_lat4: got %0h expected %0h", {red, green, blue}, golden[3]); end
    endtask

    task automatic test_dropped();
        int lat; logic drop, we; logic [14:0] ma; logic [11:0] md; logic [11:0] d;
        hblank = 1'b1;
        do_write(15'd19200, 12'($urandom), 5, lat, drop, we, ma, md);
        n_checks++; if ({lat == 1, drop, we} !== 3'b110) begin n_fail++; $display("FAIL drop_oob: got lat %0d drop %b we %b expected 1 1 0", lat, drop, we); end
        tick();
        n_checks++; if ({wr_dropped, mem_we} !== 2'b00) begin n_fail++; $display("FAIL drop_pulse: got %b expected 00", {wr_dropped, mem_we}); end
        d = 12'($urandom);
        do_write(15'd19199, d, 5, lat, drop, we, ma, md);
        n_checks++; if ({lat == 1, drop, we} !== 3'b101) begin n_fail++; $display("FAIL drop_last_in_range: got lat %0d drop %b we %b expected 1 0 1", lat, drop, we); end
        golden[19199] = d;
        tick();
        set_pix(639, 479);
        tick(); tick(); tick();
        n_checks++; if ({red, green, blue} !== golden[19199]) begin n_fail++; $display("FAIL corner_pixel: got %0h expected %0h", {red, green, blue}, golden[19199]); end
    endtask

    task automatic test_blank_only();
        int pulses, lat, extra; logic [11:0] d;
        d = 12'($urandom);
        set_pix(100, 100);
        wr_valid = 1'b1; wr_addr = 15'd7; wr_data = d;
        golden[7] = d;
        pulses = 0;
        repeat (20) begin tick(); if (wr_ready_b) pulses++; end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL blank_only_visible: got %0d pulses expected 0", pulses); end
        vblank = 1'b1;
        lat = -1;
        for (int i = 1; i <= 5; i++) begin tick(); if (wr_ready_b) begin lat = i; break; end end
        wr_valid = 1'b0;
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL blank_only_grant: got latency %0d expected 1", lat); end
        extra = 0;
        repeat (5) begin tick(); if (wr_ready_b) extra++; end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL blank_only_once: got %0d extra pulses expected 0", extra); end
    endtask

    task automatic test_reset_in_wr();
        int lat; logic drop, we; logic [14:0] ma; logic [11:0] md; logic [11:0] old;
        set_pix(20, 8);
        tick(); tick(); tick(); tick();
        n_checks++; if ({red, green, blue} !== golden[325]) begin n_fail++; $display("FAIL rwr_pre: got %0h expected %0h", {red, green, blue}, golden[325]); end
        old = golden[325];
        do_write(15'd325, old ^ 12'hFFF, 5, lat, drop, we, ma, md);
        n_checks++; if ({lat == 1, we} !== 2'b11) begin n_fail++; $display("FAIL rwr_enter: got lat %0d we %b expected 1 1", lat, we); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if ({mem_we, wr_ready, wr_dropped} !== 3'b000) begin n_fail++; $display("FAIL rwr_abort: got %b expected 000", {mem_we, wr_ready, wr_dropped}); end
        n_checks++; if ({mem_addr, mem_wdata, red, green, blue} !== '0) begin
            n_fail++; $display("FAIL rwr_outputs: got addr %0h data %0h rgb %0h expected 0", mem_addr, mem_wdata, {red, green, blue}); end
        tick();
        n_checks++; if (mem[325] !== old) begin n_fail++; $display("FAIL rwr_no_write: got %0h expected %0h", mem[325], old); end
        tick(); rst = 1'b0;
        tick();
        n_checks++; if (mem_addr !== 15'd325) begin n_fail++; $display("FAIL rwr_refetch: got %0d expected 325", mem_addr); end
        tick(); tick();
        n_checks++; if ({red, green, blue} !== old) begin n_fail++; $display("FAIL rwr_pixel: got %0h expected %0h", {red, green, blue}, old); end
    endtask

    task automatic test_random();
        int lat, a, x, y, last_a; logic drop, we, exp_drop; logic [14:0] ma; logic [11:0] md, d;
        last_a = 0;
        for (int r = 0; r < 6; r++) begin
            hblank = 1'b1;
            for (int k = 0; k < 4; k++) begin
                a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(19200, 32767)) : int'($urandom_range(0, 19199));
                d = 12'($urandom);
                exp_drop = (a >= FB_SIZE);
                do_write(15'(a), d, 5, lat, drop, we, ma, md);
                n_checks++; if ({lat == 1, drop, we, ma} !== {1'b1, exp_drop, !exp_drop, 15'(a)}) begin
                    n_fail++; $display("FAIL rand_write: got lat %0d drop %b we %b addr %0d expected 1 %b %b %0d", lat, drop, we, ma, exp_drop, !exp_drop, a); end
                if (!exp_drop) begin golden[a] = d; last_a = a; end
                tick();
            end
            for (int p = 0; p < 10; p++) begin
                if ($urandom_range(0, 2) == 0) begin
                    x = (last_a % 160) * 4 + int'($urandom_range(0, 3));
                    y = (last_a / 160) * 4 + int'($urandom_range(0, 3));
                end else begin
                    x = int'($urandom_range(0, 639));
                    y = int'($urandom_range(0, 479));
                end
                set_pix(x, y);
                tick(); tick(); tick();
                n_checks++; if ({red, green, blue} !== golden[pix_addr(x, y)]) begin
                    n_fail++; $display("FAIL rand_pixel (%0d,%0d): got %0h expected %0h", x, y, {red, green, blue}, golden[pix_addr(x, y)]); end
                hblank = 1'b1; #1;
                n_checks++; if ({red, green, blue} !== 12'h000) begin n_fail++; $display("FAIL rand_hblank_rgb: got %0h expected 0", {red, green, blue}); end
                hblank = 1'b0; cur_x = 11'($urandom_range(640, 2047)); #1;
                n_checks++; if ({red, green, blue} !== 12'h000) begin n_fail++; $display("FAIL rand_offscreen_rgb: got %0h expected 0", {red, green, blue}); end
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_pixel();
        test_write_hblank();
        test_collision();
        test_dropped();
        test_blank_only();
        test_reset_in_wr();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
